ntt_stage_ctrl: RTL and testbench
=================================

# ntt_stage_ctrl

Stage sequencer for the 8-bank, 8-butterfly NTT datapath. On a start pulse it walks the seven butterfly stages: len 128→2 for NTT, len 2→128 for iNTT. For each stage it issues the BRAM read sweep and drives the butterfly-selector stage length and enable. It delays the matching write-back strobes by the pipeline latency and drains the pipeline between stages so that no stage reads data the previous stage has not yet written.

## Interface
Parameters:
- RD_LAT, 1: BRAM read latency, in cycles from address to data.
- BU_LAT, 3: butterfly latency, in cycles from input to output.
- ADDR_W, 5: per-bank address width (32 words per bank).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a transform; sampled only in IDLE.
- is_ntt_i  in  1  direction: 1 = NTT, 0 = iNTT; captured with start_i.
- stall_i  in  1  pause read issue. Present only with NTT_CTRL_STALL_EN.
- busy_o  out  1  high in READ and DRAIN.
- done_o  out  1  one-cycle pulse in the DONE state.
- len_o  out  8  stage length, to the butterfly selector and the zeta ROM.
- is_ntt_o  out  1  captured direction.
- bu_start_o  out  1  butterfly-selector enable.
- rd_en_o  out  1  read strobe to all 8 banks.
- rd_addr_a_o / rd_addr_b_o  out  ADDR_W  port A and port B read addresses.
- wr_en_o  out  1  write-back strobe.
- wr_addr_a_o / wr_addr_b_o  out  ADDR_W  port A and port B write addresses.

## Operation
- Define L = RD_LAT + BU_LAT.
- States: IDLE, READ, DRAIN, DONE.
- IDLE → READ when start_i = 1.
  - Captures is_ntt_i.
  - Sets len_o to 128 for NTT, 2 for iNTT.
  - Clears the 4-bit cycle counter c and the 3-bit stage counter s.
- READ:
  - rd_en_o = 1.
  - rd_addr_a_o = {0, c[3:0]}; rd_addr_b_o = {1, c[3:0]}. Port A sweeps words 0–15 and port B sweeps words 16–31 of every bank.
  - c increments every cycle.
  - When c = 15: go to DRAIN, clear the drain counter.
- DRAIN:
  - Lasts exactly L cycles; rd_en_o = 0; len_o is held.
  - On exit with s < 6: s increments, len_o halves (NTT) or doubles (iNTT), go to READ.
  - On exit with s = 6: go to DONE.
- DONE: done_o = 1 for one cycle, then IDLE. len_o and is_ntt_o hold until the next start.
- bu_start_o is rd_en_o delayed by RD_LAT cycles.
- wr_en_o and wr_addr_*_o are rd_en_o and rd_addr_*_o delayed by L cycles through a shift pipeline.
- start_i while not in IDLE is ignored.
- rst_i asserted at any time:
  - Next state is IDLE.
  - The write-back pipeline is flushed; no write strobe appears after reset.
- Reset value of every output is 0, including len_o.

## Timing
- Take start_i high on cycle 0.
  - First rd_en_o is on cycle 1.
  - First bu_start_o is on cycle 1+RD_LAT.
  - First wr_en_o is on cycle 1+L.
- Each stage occupies 16+L cycles: reads start 16+L cycles apart.
- The last write of a stage precedes the first read of the next stage by exactly one cycle.
- done_o is on cycle 1 + 7·(16+L). With the defaults this is cycle 141.
- busy_o falls in the same cycle that done_o rises.

## Configuration
- With NTT_CTRL_STALL_EN defined:
  - Port stall_i exists.
  - In READ with stall_i = 1: rd_en_o = 0, and c and the addresses hold.
  - The bu_start/write-back pipelines keep shifting, because the butterflies have no enable. In-flight writes still complete.
  - Stall in DRAIN or DONE has no effect.
- Without NTT_CTRL_STALL_EN: the port is absent and the read sweep is unconditional.

## Structure
- ntt_pkg holds:
  - the state enum;
  - the constants N_COEFF = 256, N_BANK = 8, N_STAGE = 7, CYC_PER_STAGE = 16;
  - LEN_FIRST_NTT = 128 and LEN_FIRST_INTT = 2.
- Sub-module ntt_wb_delay: a parameterised-depth shift register carrying {en, addr_a, addr_b}. It is instantiated twice:
  - depth RD_LAT, for bu_start_o;
  - depth L, for the write-back outputs.

## Test plan
- NTT, default parameters, start on cycle 0:
  - len_o sequence 128, 64, 32, 16, 8, 4, 2;
  - 112 rd_en_o cycles and 112 wr_en_o cycles;
  - done_o on cycle 141 only.
- iNTT: len_o sequence 2, 4, …, 128; first wr_addr_a_o = 0 and first wr_addr_b_o = 16 on cycle 5.
- Hazard check, all stages: for every stage, the cycle of its last wr_en_o + 1 equals the cycle of the next stage's first rd_en_o.
- start_i pulsed on cycle 30 during busy: no effect, and done_o is still on cycle 141.
- rst_i on cycle 50:
  - all outputs 0 on cycle 51;
  - no wr_en_o afterwards;
  - a new start then completes normally.
- NTT_CTRL_STALL_EN, stall_i high on cycles 5–7:
  - rd_addr_a_o holds at 4;
  - wr_en_o continues for the 4 in-flight reads;
  - done_o shifts to cycle 144.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT stage sequencer.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int N_COEFF       = 256;
  localparam int N_BANK        = 8;
  localparam int N_STAGE       = 7;
  localparam int CYC_PER_STAGE = 16;

  localparam logic [7:0] LEN_FIRST_NTT  = 8'd128;
  localparam logic [7:0] LEN_FIRST_INTT = 8'd2;

endpackage

// File: rtl/ntt_wb_delay.sv
// Fixed-depth shift register that delays a {en, addr_a, addr_b} bundle.
// A synchronous reset clears every stage so no stale strobe leaks out.
module ntt_wb_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// Stage sequencer for the 8-bank NTT datapath: read sweep, pipeline drain, delayed write-back.
// Optional read-stall input is enabled with `define NTT_CTRL_STALL_EN.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for start_i, len/direction held
// ST_READ  | 16-cycle read sweep of the current stage
// ST_DRAIN | RD_LAT+BU_LAT cycles letting the pipeline empty
// ST_DONE  | one-cycle done pulse
module ntt_stage_ctrl
  import ntt_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int BU_LAT = 3,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              is_ntt_i,
`ifdef NTT_CTRL_STALL_EN
  input  logic              stall_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        len_o,
  output logic              is_ntt_o,
  output logic              bu_start_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_a_o,
  output logic [ADDR_W-1:0] wr_addr_b_o
);

  localparam int L    = RD_LAT + BU_LAT;
  localparam int DW   = $clog2(L + 1);
  localparam int WB_W = 1 + 2 * ADDR_W;

  state_t          state_q, state_d;
  logic [3:0]      c_q, c_d;
  logic [2:0]      s_q, s_d;
  logic [DW-1:0]   d_q, d_d;
  logic [7:0]      len_q, len_d;
  logic            dir_q, dir_d;
  logic            stall;
  logic            rd_en;
  logic [WB_W-1:0] wb_q;

`ifdef NTT_CTRL_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      s_q     <= '0;
      d_q     <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      s_q     <= s_d;
      d_q     <= d_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    s_d     = s_q;
    d_d     = d_q;
    len_d   = len_q;
    dir_d   = dir_q;
    rd_en   = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_READ;
          dir_d   = is_ntt_i;
          len_d   = is_ntt_i ? LEN_FIRST_NTT : LEN_FIRST_INTT;
          c_d     = '0;
          s_d     = '0;
        end
      end
      ST_READ: begin
        busy_o = 1'b1;
        if (!stall) begin
          rd_en = 1'b1;
          c_d   = c_q + 4'd1;
          if (c_q == 4'(CYC_PER_STAGE - 1)) begin
            state_d = ST_DRAIN;
            d_d     = '0;
          end
        end
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        if (d_q == DW'(L - 1)) begin
          if (s_q == 3'(N_STAGE - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
            s_d     = s_q + 3'd1;
            c_d     = '0;
            len_d   = dir_q ? (len_q >> 1) : (len_q << 1);
          end
        end else begin
          d_d = d_q + DW'(1);
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses follow c throughout READ so they hold steady across a stall.
  assign rd_en_o     = rd_en;
  assign rd_addr_a_o = (state_q == ST_READ) ? ADDR_W'({1'b0, c_q}) : '0;
  assign rd_addr_b_o = (state_q == ST_READ) ? ADDR_W'({1'b1, c_q}) : '0;
  assign len_o       = len_q;
  assign is_ntt_o    = dir_q;

  ntt_wb_delay #(.DEPTH(RD_LAT), .W(1)) u_bu_delay (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (rd_en),
    .dout (bu_start_o)
  );

  ntt_wb_delay #(.DEPTH(L), .W(WB_W)) u_wb_delay (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  ({rd_en, rd_addr_a_o, rd_addr_b_o}),
    .dout (wb_q)
  );

  assign wr_en_o     = wb_q[WB_W-1];
  assign wr_addr_a_o = wb_q[2*ADDR_W-1:ADDR_W];
  assign wr_addr_b_o = wb_q[ADDR_W-1:0];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl: a cycle-level event model feeds queues that a monitor drains.
`timescale 1ns/1ps
module tb_ntt_stage_ctrl;

  localparam int RD_LAT = 1;
  localparam int BU_LAT = 3;
  localparam int ADDR_W = 5;
  localparam int L      = RD_LAT + BU_LAT;

  logic clk = 1'b0;
  logic rst_i, start_i, is_ntt_i, stall_i;
  logic busy_o, done_o, is_ntt_o, bu_start_o, rd_en_o, wr_en_o;
  logic [7:0] len_o;
  logic [ADDR_W-1:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;

  always #5 clk = ~clk;

  ntt_stage_ctrl #(.RD_LAT(RD_LAT), .BU_LAT(BU_LAT), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .is_ntt_i    (is_ntt_i),
`ifdef NTT_CTRL_STALL_EN
    .stall_i     (stall_i),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .len_o       (len_o),
    .is_ntt_o    (is_ntt_o),
    .bu_start_o  (bu_start_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_a_o (wr_addr_a_o),
    .wr_addr_b_o (wr_addr_b_o)
  );

  typedef struct {
    int cyc;
    int a;
    int b;
    int len;
    int dir;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t bu_q[$];
  int  done_q[$];
  bit  stall_at[int];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int busy_lo = 0;
  int busy_hi = 0;
  int rst_chk = -1;
  bit mon_en = 1'b0;
  ev_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  initial begin
    stall_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stall_i = stall_at.exists(cyc);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 64'(busy_o), 64'(cyc >= busy_lo && cyc < busy_hi));
      if (cyc == rst_chk) begin
        chk("rst_ctrl_zero", {busy_o, done_o, len_o, is_ntt_o, bu_start_o, rd_en_o, wr_en_o}, 0);
        chk("rst_addr_zero", {rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o}, 0);
      end
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        chk("rd_missing", cyc, rd_q[0].cyc);
        void'(rd_q.pop_front());
      end
      if (rd_en_o !== 1'b0) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 64'(rd_en_o), 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_cyc", cyc, e.cyc);
          chk("rd_addr_a", rd_addr_a_o, e.a);
          chk("rd_addr_b", rd_addr_b_o, e.b);
          chk("len", len_o, e.len);
          chk("is_ntt", 64'(is_ntt_o), e.dir);
        end
      end
      while (bu_q.size() > 0 && bu_q[0].cyc < cyc) begin
        chk("bu_missing", cyc, bu_q[0].cyc);
        void'(bu_q.pop_front());
      end
      if (bu_start_o !== 1'b0) begin
        if (bu_q.size() == 0) chk("bu_unexpected", 64'(bu_start_o), 0);
        else begin
          e = bu_q.pop_front();
          chk("bu_cyc", cyc, e.cyc);
        end
      end
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        chk("wr_missing", cyc, wr_q[0].cyc);
        void'(wr_q.pop_front());
      end
      if (wr_en_o !== 1'b0) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 64'(wr_en_o), 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_cyc", cyc, e.cyc);
          chk("wr_addr_a", wr_addr_a_o, e.a);
          chk("wr_addr_b", wr_addr_b_o, e.b);
        end
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        chk("done_missing", cyc, done_q[0]);
        void'(done_q.pop_front());
      end
      if (done_o !== 1'b0) begin
        if (done_q.size() == 0) chk("done_unexpected", 64'(done_o), 0);
        else chk("done_cyc", cyc, done_q.pop_front());
      end
    end
  end

  // One transform: spur = relative cycle of an ignored start pulse, rst_at = relative reset cycle,
  // stall_mode 1 = stall on relative cycles 5..7, 2 = random stalls.
  task automatic run_xfer(input bit dir, input int spur, input int rst_at, input int stall_mode);
    int t0, t, done_c, lim, r, len;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_i  = 1'b1;
    is_ntt_i = dir;
`ifdef NTT_CTRL_STALL_EN
    if (stall_mode == 1) for (int i = 5; i <= 7; i++) stall_at[t0 + i] = 1'b1;
    if (stall_mode == 2) for (int i = 0; i < 8; i++) stall_at[t0 + 1 + $urandom_range(0, 150)] = 1'b1;
`endif
    t = t0 + 1;
    for (int k = 0; k < 7; k++) begin
      len = dir ? (128 >> k) : (2 << k);
      for (int j = 0; j < 16; j++) begin
        while (stall_at.exists(t)) t++;
        rd_q.push_back('{t, j, 16 + j, len, int'(dir)});
        bu_q.push_back('{t + RD_LAT, 0, 0, 0, 0});
        wr_q.push_back('{t + L, j, 16 + j, 0, 0});
        t++;
      end
      t += L;
    end
    done_c = t;
    done_q.push_back(done_c);
    busy_lo = t0 + 1;
    busy_hi = done_c;
    r   = (rst_at > 0) ? t0 + rst_at : -1;
    lim = (rst_at > 0) ? r + 1 : done_c;
    forever begin
      @(posedge clk);
      #1;
      start_i  = (spur > 0 && cyc == t0 + spur);
      is_ntt_i = 1'($urandom);
      rst_i    = (cyc == r);
      if (cyc == r) begin
        while (rd_q.size() > 0 && rd_q[$].cyc > r) void'(rd_q.pop_back());
        while (bu_q.size() > 0 && bu_q[$].cyc > r) void'(bu_q.pop_back());
        while (wr_q.size() > 0 && wr_q[$].cyc > r) void'(wr_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > r) void'(done_q.pop_back());
        if (busy_hi > r + 1) busy_hi = r + 1;
        rst_chk = r + 1;
      end
      if (cyc >= lim) break;
    end
    start_i = 1'b0;
  endtask

  initial begin
    int sp, ra;
    rst_i    = 1'b1;
    start_i  = 1'b0;
    is_ntt_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_i   = 1'b0;
    rst_chk = cyc;
    mon_en  = 1'b1;
    repeat (2) @(posedge clk);

    run_xfer(1'b1, 0, 0, 0);
    run_xfer(1'b0, 0, 0, 0);
    run_xfer(1'b1, 30, 0, 0);
    run_xfer(1'b1, 0, 50, 0);
    repeat (6) @(posedge clk);
    run_xfer(1'b0, 0, 0, 0);
`ifdef NTT_CTRL_STALL_EN
    run_xfer(1'b1, 0, 0, 1);
`endif
    for (int i = 0; i < 6; i++) begin
      sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 140)) : 0;
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 130)) : 0;
      if (ra > 0 && sp >= ra) sp = 0;
      run_xfer(1'($urandom), sp, ra, 2);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("rd_q_left", rd_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    chk("bu_q_left", bu_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
